// File: rtl/zram_arbiter.sv
// Three-way arbiter (video / CPU / loader) in front of a single-port zram, all RAM-side signals
// registered. Define ZARB_STATS_EN to build the saturating CPU wait-cycle counter on stat_cwait_o.
module zram_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned VBURST = 4
) (
    input  logic          clock_i,
    input  logic          resetn_i,
    input  logic          v_req_i,
    input  logic [AW-1:0] v_addr_i,
    output logic          v_ack_o,
    output logic          v_rvalid_o,
    input  logic          c_req_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic          c_we_i,
    input  logic [DW-1:0] c_wdata_i,
    output logic          c_ack_o,
    output logic          c_rvalid_o,
    input  logic          l_req_i,
    input  logic [AW-1:0] l_addr_i,
    input  logic          l_we_i,
    input  logic [DW-1:0] l_wdata_i,
    output logic          l_ack_o,
    output logic          l_rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] ram_address_o,
    output logic [DW-1:0] ram_data_o,
    output logic          ram_wren_o,
    input  logic [DW-1:0] ram_q_i,
    output logic [15:0]   stat_cwait_o
);

    typedef enum logic [1:0] {PNone, PVid, PCpu, PLdr} port_e;

    localparam logic [3:0] BurstMax = 4'(VBURST);

    logic          v_ack_q, c_ack_q, l_ack_q;
    logic          elig_v, elig_c, elig_l, other_pend;
    port_e         grant, rd_tag_d, tag1_q, tag2_q;
    logic [3:0]    burst_d, burst_q;
    logic          rr_d, rr_q; // 0: CPU preferred, 1: loader preferred
    logic [AW-1:0] addr_d, addr_q;
    logic [DW-1:0] data_d, data_q, rdata_q;
    logic          wren_d, wren_q;

    always_comb begin
        elig_v     = v_req_i & ~v_ack_q;
        elig_c     = c_req_i & ~c_ack_q;
        elig_l     = l_req_i & ~l_ack_q;
        other_pend = elig_c | elig_l;

        grant = PNone;
        if (elig_v && !(other_pend && burst_q == BurstMax)) begin
            grant = PVid;
        end else if (elig_c && (!elig_l || !rr_q)) begin
            grant = PCpu;
        end else if (elig_l) begin
            grant = PLdr;
        end

        burst_d = '0;
        if (other_pend && grant == PVid) begin
            burst_d = (burst_q == BurstMax) ? burst_q : burst_q + 4'd1;
        end

        rr_d     = rr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        rd_tag_d = PNone;
        unique case (grant)
            PVid: begin
                addr_d   = v_addr_i;
                rd_tag_d = PVid;
            end
            PCpu: begin
                rr_d     = 1'b1;
                addr_d   = c_addr_i;
                data_d   = c_wdata_i;
                wren_d   = c_we_i;
                rd_tag_d = c_we_i ? PNone : PCpu;
            end
            PLdr: begin
                rr_d     = 1'b0;
                addr_d   = l_addr_i;
                data_d   = l_wdata_i;
                wren_d   = l_we_i;
                rd_tag_d = l_we_i ? PNone : PLdr;
            end
            PNone: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            v_ack_q <= 1'b0;
            c_ack_q <= 1'b0;
            l_ack_q <= 1'b0;
            tag1_q  <= PNone;
            tag2_q  <= PNone;
            burst_q <= '0;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            v_ack_q <= (grant == PVid);
            c_ack_q <= (grant == PCpu);
            l_ack_q <= (grant == PLdr);
            tag1_q  <= rd_tag_d;
            tag2_q  <= tag1_q;
            burst_q <= burst_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            rdata_q <= rdata_o;
        end
    end

    // zram's q_a is already registered, so read data passes straight through in T+2 and is
    // held afterwards so rdata_o stays stable between strobes.
    assign rdata_o       = (tag2_q != PNone) ? ram_q_i : rdata_q;
    assign v_ack_o       = v_ack_q;
    assign c_ack_o       = c_ack_q;
    assign l_ack_o       = l_ack_q;
    assign v_rvalid_o    = (tag2_q == PVid);
    assign c_rvalid_o    = (tag2_q == PCpu);
    assign l_rvalid_o    = (tag2_q == PLdr);
    assign ram_address_o = addr_q;
    assign ram_data_o    = data_q;
    assign ram_wren_o    = wren_q;

`ifdef ZARB_STATS_EN
    logic [15:0] cwait_d, cwait_q;

    always_comb begin
        cwait_d = cwait_q;
        if (c_req_i && !c_ack_q && cwait_q != 16'hFFFF) begin
            cwait_d = cwait_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cwait_q <= '0;
        end else begin
            cwait_q <= cwait_d;
        end
    end

    assign stat_cwait_o = cwait_q;
`else
    assign stat_cwait_o = 16'h0000;
`endif

endmodule

// File: tb/tb_zram_arbiter.sv
// Self-checking bench for zram_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (grant rules, shadow memory, pipeline of expected strobes).
module tb_zram_arbiter;

    localparam int GN = 0, GV = 1, GC = 2, GL = 3;
    localparam int VBURST = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        v_req = 1'b0, c_req = 1'b0, l_req = 1'b0;
    logic [15:0] v_addr = '0, c_addr = '0, l_addr = '0;
    logic        c_we = 1'b0, l_we = 1'b0;
    logic [7:0]  c_wdata = '0, l_wdata = '0;
    logic        v_ack, c_ack, l_ack, v_rvalid, c_rvalid, l_rvalid;
    logic [7:0]  rdata, ram_data, ram_q;
    logic [15:0] ram_address, stat_cwait;
    logic        ram_wren;

    always #5 clk = ~clk;

    zram_arbiter #(.AW(16), .DW(8), .VBURST(VBURST)) dut (
        .clock_i(clk), .resetn_i(rstn),
        .v_req_i(v_req), .v_addr_i(v_addr), .v_ack_o(v_ack), .v_rvalid_o(v_rvalid),
        .c_req_i(c_req), .c_addr_i(c_addr), .c_we_i(c_we), .c_wdata_i(c_wdata),
        .c_ack_o(c_ack), .c_rvalid_o(c_rvalid),
        .l_req_i(l_req), .l_addr_i(l_addr), .l_we_i(l_we), .l_wdata_i(l_wdata),
        .l_ack_o(l_ack), .l_rvalid_o(l_rvalid),
        .rdata_o(rdata), .ram_address_o(ram_address), .ram_data_o(ram_data),
        .ram_wren_o(ram_wren), .ram_q_i(ram_q), .stat_cwait_o(stat_cwait)
    );

    // zram stand-in: single port, registered read
    logic [7:0] zmem [0:65535];
    always @(posedge clk) begin
        if (ram_wren) zmem[ram_address] <= ram_data;
        ram_q <= zmem[ram_address];
    end

    int n_tests = 0, n_fail = 0;

    // reference model state
    logic [7:0]  shadow [0:65535];
    bit          known  [0:65535];
    int          g1 = GN, s2 = GN;
    bit          g1_rd = 0;
    logic [7:0]  g1_data = '0, s2_data = '0;
    bit          g1_known = 0, s2_known = 0;
    logic [15:0] exp_addr = '0;
    logic [7:0]  exp_data = '0;
    bit          exp_wren = 0;
    int          burst = 0;
    bit          pref_cpu = 1;
    int          cw = 0;

    // stimulus knobs
    int          pv = 0, pc = 0, pl = 0;
    bit          c_scr = 0, l_scr = 0, c_scr_we = 0, l_scr_we = 0;
    logic [15:0] c_scr_addr = '0, l_scr_addr = '0;
    logic [7:0]  c_scr_data = '0, l_scr_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        g1 = GN; s2 = GN; g1_rd = 0; g1_known = 0; s2_known = 0;
        exp_addr = '0; exp_data = '0; exp_wren = 0;
        burst = 0; pref_cpu = 1; cw = 0;
    endtask

    task automatic take_read(input logic [15:0] a);
        g1_rd = 1; g1_data = shadow[a]; g1_known = known[a];
    endtask

    task automatic cycle();
        bit ev, ec, el, other;
        int g;
        @(negedge clk);
        check("v_ack", 32'(v_ack), 32'(g1 == GV));
        check("c_ack", 32'(c_ack), 32'(g1 == GC));
        check("l_ack", 32'(l_ack), 32'(g1 == GL));
        check("v_rvalid", 32'(v_rvalid), 32'(s2 == GV));
        check("c_rvalid", 32'(c_rvalid), 32'(s2 == GC));
        check("l_rvalid", 32'(l_rvalid), 32'(s2 == GL));
        if (s2 != GN && s2_known) check("rdata", 32'(rdata), 32'(s2_data));
        check("ram_wren", 32'(ram_wren), 32'(exp_wren));
        check("ram_address", 32'(ram_address), 32'(exp_addr));
        check("ram_data", 32'(ram_data), 32'(exp_data));
        check("stat_cwait", 32'(stat_cwait), 32'(cw));

        // requesters: hold until acked, then optionally issue a new request
        if (!v_req || g1 == GV) begin
            v_req  = ($urandom_range(99) < pv);
            v_addr = 16'($urandom_range(31));
        end
        if (!c_req || g1 == GC) begin
            if (c_scr) begin
                c_req = 1; c_addr = c_scr_addr; c_we = c_scr_we; c_wdata = c_scr_data; c_scr = 0;
            end else begin
                c_req = ($urandom_range(99) < pc);
                c_addr = 16'($urandom_range(31)); c_we = 1'($urandom_range(1));
                c_wdata = 8'($urandom);
            end
        end
        if (!l_req || g1 == GL) begin
            if (l_scr) begin
                l_req = 1; l_addr = l_scr_addr; l_we = l_scr_we; l_wdata = l_scr_data; l_scr = 0;
            end else begin
                l_req = ($urandom_range(99) < pl);
                l_addr = 16'($urandom_range(31)); l_we = 1'($urandom_range(1));
                l_wdata = 8'($urandom);
            end
        end

        // arbitration rules
        ev = v_req && g1 != GV;
        ec = c_req && g1 != GC;
        el = l_req && g1 != GL;
        other = ec || el;
        if (ev && !(other && burst == VBURST)) g = GV;
        else if (ec && el) g = pref_cpu ? GC : GL;
        else if (ec) g = GC;
        else if (el) g = GL;
        else g = GN;
        if (!other || g != GV) burst = 0;
        else if (burst < VBURST) burst++;
`ifdef ZARB_STATS_EN
        if (c_req && g1 != GC && cw < 65535) cw++;
`endif
        s2 = g1_rd ? g1 : GN;
        s2_data = g1_data; s2_known = g1_known;
        g1 = g; g1_rd = 0; g1_known = 0;
        exp_wren = 0;
        case (g)
            GV: begin exp_addr = v_addr; take_read(v_addr); end
            GC: begin
                pref_cpu = 0; exp_addr = c_addr; exp_data = c_wdata; exp_wren = c_we;
                if (c_we) begin shadow[c_addr] = c_wdata; known[c_addr] = 1; end
                else take_read(c_addr);
            end
            GL: begin
                pref_cpu = 1; exp_addr = l_addr; exp_data = l_wdata; exp_wren = l_we;
                if (l_we) begin shadow[l_addr] = l_wdata; known[l_addr] = 1; end
                else take_read(l_addr);
            end
            default: ;
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cnt_c, cnt_l;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_acks", 32'({v_ack, c_ack, l_ack}), 32'h0);
        check("rst_rvalids", 32'({v_rvalid, c_rvalid, l_rvalid}), 32'h0);
        check("rst_wren", 32'(ram_wren), 32'h0);
        check("rst_addr", 32'(ram_address), 32'h0);
        check("rst_data_rdata", 32'({ram_data, rdata}), 32'h0);
        check("rst_stat", 32'(stat_cwait), 32'h0);
        rstn = 1'b1;
        model_reset();

        // 1: preload 1234=A5 via loader, then lone CPU read
        l_scr = 1; l_scr_we = 1; l_scr_addr = 16'h1234; l_scr_data = 8'hA5;
        run(4);
        c_scr = 1; c_scr_we = 0; c_scr_addr = 16'h1234;
        cycle();
        cycle();
        check("t1_c_ack", 32'(c_ack), 32'h1);
        cycle();
        check("t1_c_rvalid", 32'(c_rvalid), 32'h1);
        check("t1_rdata", 32'(rdata), 32'hA5);
        run(2);

        // 2: CPU write then read back
        c_scr = 1; c_scr_we = 1; c_scr_addr = 16'h0100; c_scr_data = 8'h3C;
        cycle();
        cycle();
        check("t2_wren", 32'({ram_wren, ram_address, ram_data}), {15'h0, 1'b1, 16'h0100, 8'h3C});
        cycle();
        check("t2_wren_drop", 32'({ram_wren, c_rvalid}), 32'h0);
        c_scr = 1; c_scr_we = 0; c_scr_addr = 16'h0100;
        run(3);
        check("t2_readback", 32'({c_rvalid, rdata}), {23'h0, 1'b1, 8'h3C});
        run(2);

        // 3/6: video and CPU saturating; CPU must keep getting through
        pv = 100; pc = 100; pl = 0; cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (c_ack) cnt_c++;
        end
        check("t3_cpu_share", 32'(cnt_c >= 6), 32'h1);
`ifdef ZARB_STATS_EN
        check("t6_stat_nonzero", 32'(stat_cwait != 16'h0), 32'h1);
`else
        check("t6_stat_zero", 32'(stat_cwait), 32'h0);
`endif

        // 4: CPU and loader saturating, no video
        pv = 0; pc = 100; pl = 100; cnt_c = 0; cnt_l = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (c_ack) cnt_c++;
            if (l_ack) cnt_l++;
        end
        check("t4_balance", 32'(cnt_c >= 8 && cnt_l >= 8), 32'h1);
        pc = 0; pl = 0;
        run(4);

        // 5: reset during T+1 of a write
        c_scr = 1; c_scr_we = 1; c_scr_addr = 16'h0050; c_scr_data = 8'h11;
        run(4);
        c_scr = 1; c_scr_we = 1; c_scr_addr = 16'h0050; c_scr_data = 8'h77;
        cycle();
        cycle();
        #2 rstn = 1'b0;
        #1;
        check("t5_wren", 32'(ram_wren), 32'h0);
        check("t5_outs", 32'({v_ack, c_ack, l_ack, v_rvalid, c_rvalid, l_rvalid, ram_address}), 32'h0);
        v_req = 0; c_req = 0; l_req = 0;
        shadow[16'h0050] = 8'h11;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("t5_no_write", 32'(zmem[16'h0050]), 32'h11);
        rstn = 1'b1;
        c_scr = 1; c_scr_we = 0; c_scr_addr = 16'h0050;
        l_scr = 1; l_scr_we = 0; l_scr_addr = 16'h1234;
        cycle();
        cycle();
        check("t5_first_cpu", 32'({c_ack, l_ack}), 32'h2);
        run(4);

        // randomized traffic
        for (int ph = 0; ph < 6; ph++) begin
            pv = $urandom_range(100); pc = $urandom_range(100); pl = $urandom_range(100);
            run(250);
        end
        pv = 0; pc = 0; pl = 0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
